// File: rtl/bec_dec_serial.sv
// Nibble-serial minus-one converter: y = a - dec over WIDTH bits, one nibble per clock, LSB first.
// WIDTH must be a multiple of 4 and at least 8; valid/ready handshake on both sides.
module bec_dec_serial #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic             dec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             bout
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = $clog2(NIB);
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  state_t          state_nx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] y_q;
  logic             borrow;
  logic             bout_q;
  logic [IW-1:0]    idx;
  logic [3:0]       nib;
  logic [3:0]       diff;
  logic             borrow_nx;

  // Once the borrow clears, later nibbles subtract zero and copy through.
  assign nib       = a_q[4*idx +: 4];
  assign diff      = nib - {3'b000, borrow};
  assign borrow_nx = borrow & (nib == 4'h0);

  assign y    = y_q;
  assign bout = bout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nx = RUN;
        end
      end
      RUN: begin
        if (idx == LAST) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      y_q    <= '0;
      borrow <= 1'b0;
      bout_q <= 1'b0;
      idx    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q    <= a;
            borrow <= dec;
            idx    <= '0;
          end
        end
        RUN: begin
          y_q[4*idx +: 4] <= diff;
          borrow          <= borrow_nx;
          if (idx == LAST) begin
            bout_q <= borrow_nx;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bec_dec_serial.sv
// Directed bench for bec_dec_serial: latency, borrow chains, wrap-around, backpressure,
// mid-run reset and back-to-back throughput against hand-computed results.
module tb_bec_dec_serial;

  localparam int WIDTH = 32;
  localparam int NIB   = WIDTH / 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic             dec;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             bout;

  int compared;
  int mismatched;
  int cyc;

  bec_dec_serial #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .dec       (dec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .bout      (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present an operand from a falling edge and hold it until the accepting rising edge.
  task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic dv);
    int guard;
    @(negedge clk);
    a        = av;
    dec      = dv;
    in_valid = 1'b1;
    guard    = 0;
    while (!in_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) checkOutput("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Called right after the accept edge: checks latency and the delivered result, then consumes it.
  task automatic waitResult(input string tag, input logic [WIDTH-1:0] ey, input logic eb);
    int lat;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!out_valid && lat < 20);
    checkOutput({tag, "_latency"}, 32'(lat), 32'(NIB));
    checkOutput({tag, "_y"}, y, ey);
    checkOutput({tag, "_bout"}, {31'd0, bout}, {31'd0, eb});
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] hold_y;
    logic [WIDTH-1:0] ra;
    logic             rd;
    int               last_acc;
    int               guard;

    compared   = 0;
    mismatched = 0;
    cyc        = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    a          = '0;
    dec        = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_y", y, 32'd0);
    checkOutput("rst_bout", {31'd0, bout}, 32'd0);
    rst = 1'b0;

    $display("[TB] borrow across nibble boundary, wrap-around, pass-through");
    applyStimulus(32'h0000_0010, 1'b1); waitResult("n0n1", 32'h0000_000F, 1'b0);
    applyStimulus(32'h0000_0000, 1'b1); waitResult("wrap", 32'hFFFF_FFFF, 1'b1);
    applyStimulus(32'h8000_0000, 1'b1); waitResult("msb", 32'h7FFF_FFFF, 1'b0);
    applyStimulus(32'h1234_5678, 1'b0); waitResult("pass", 32'h1234_5678, 1'b0);
    applyStimulus(32'hFFFF_FFFF, 1'b1); waitResult("ones", 32'hFFFF_FFFE, 1'b0);
    applyStimulus(32'h0000_0000, 1'b0); waitResult("zero_pass", 32'h0000_0000, 1'b0);

    $display("[TB] backpressure with a competing operand");
    applyStimulus(32'hA5A5_0000, 1'b1);
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!out_valid && guard < 20);
    checkOutput("bp_first_y", y, 32'hA5A4_FFFF);
    hold_y   = y;
    a        = 32'h0000_0003;
    dec      = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_out_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("bp_y_stable", y, hold_y);
      checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    checkOutput("bp_idle_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("bp_idle_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    waitResult("bp_second", 32'h0000_0002, 1'b0);

    $display("[TB] reset during RUN");
    applyStimulus(32'h0000_0000, 1'b1);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("mid_rst_y", y, 32'd0);
    checkOutput("mid_rst_bout", {31'd0, bout}, 32'd0);
    checkOutput("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(32'h0000_0100, 1'b1); waitResult("after_rst", 32'h0000_00FF, 1'b0);

    $display("[TB] back-to-back operands");
    out_ready = 1'b1;
    in_valid  = 1'b1;
    last_acc  = -1;
    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      rd = 1'($urandom_range(0, 1));
      if (i == 4) begin
        ra = 32'h0;
        rd = 1'b1;
      end
      if (i == 9) ra = 32'h0001_0000;
      @(negedge clk);
      a     = ra;
      dec   = rd;
      guard = 0;
      while (!in_ready && guard < 30) begin
        @(negedge clk);
        guard++;
      end
      if (!in_ready) checkOutput("b2b_accept_timeout", 32'd0, 32'd1);
      if (last_acc >= 0) checkOutput("b2b_spacing", 32'(cyc - last_acc), 32'(NIB + 2));
      last_acc = cyc;
      guard = 0;
      do begin
        @(negedge clk);
        guard++;
      end while (!out_valid && guard < 30);
      checkOutput("b2b_y", y, ra - {31'd0, rd});
      checkOutput("b2b_bout", {31'd0, bout}, {31'd0, (rd && ra == 32'd0)});
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
